// File: rtl/tetris_key_decoder.sv
// Turns the SoC's HID keycode into one-cycle game-action pulses.
// Movement keys get delayed auto-shift and auto-repeat; rotate and hard-drop fire once per press.
module tetris_key_decoder #(
    parameter int unsigned DAS_CYCLES = 8_000_000,
    parameter int unsigned ARR_CYCLES = 2_500_000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       move_left,
    output logic       move_right,
    output logic       soft_drop,
    output logic       rotate,
    output logic       hard_drop,
    output logic       key_active
);
    // state  | meaning
    // IDLE   | no accepted key; waiting for a press
    // DAS    | movement key held, counting the auto-shift delay
    // REPEAT | movement key held, pulsing every ARR_CYCLES
    // HOLD   | rotate / hard-drop held, already fired once
    // LOCK   | key was held across an enable drop; wait for release
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DAS    = 3'd1;
    localparam logic [2:0] ST_REPEAT = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_LOCK   = 3'd4;

    localparam int unsigned CNT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

    // Action vector bit order: {hard_drop, rotate, soft_drop, move_right, move_left}
    function automatic logic [4:0] decode_key(input logic [7:0] kc);
        logic [4:0] act;
        case (kc)
            8'h50, 8'h04: act = 5'b00001;
            8'h4F, 8'h07: act = 5'b00010;
            8'h51, 8'h16: act = 5'b00100;
            8'h52, 8'h1A: act = 5'b01000;
            8'h2C:        act = 5'b10000;
            default:      act = 5'b00000;
        endcase
        return act;
    endfunction

    logic [7:0]       kc_q, kc_d;
    logic [7:0]       kc_prev_q, kc_prev_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       act_q, act_d;

    logic [4:0]       key_act;
    logic             key_mapped;
    logic             key_repeat;
    logic             key_press;
    logic [2:0]       press_state;

    always_comb begin
        kc_d        = keycode;
        kc_prev_d   = kc_q;
        key_act     = decode_key(kc_q);
        key_mapped  = |key_act;
        key_repeat  = |key_act[2:0];
        key_press   = key_mapped && (kc_q != kc_prev_q);
        press_state = key_repeat ? ST_DAS : ST_HOLD;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = '0;
        if (!enable) begin
            // A key still down when the game pauses must be released before it counts again.
            state_d = key_mapped ? ST_LOCK : ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_press) begin
                        act_d   = key_act;
                        state_d = press_state;
                        cnt_d   = '0;
                    end
                end
                ST_DAS, ST_REPEAT, ST_HOLD: begin
                    if (!key_mapped) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (key_press) begin
                        act_d   = key_act;
                        state_d = press_state;
                        cnt_d   = '0;
                    end else if (state_q == ST_DAS) begin
                        if (cnt_q == DAS_LAST) begin
                            act_d   = key_act;
                            state_d = ST_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (state_q == ST_REPEAT) begin
                        if (cnt_q == ARR_LAST) begin
                            act_d = key_act;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (!key_mapped) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            kc_q      <= '0;
            kc_prev_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            act_q     <= '0;
        end else begin
            kc_q      <= kc_d;
            kc_prev_q <= kc_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
        end
    end

    // Enable gates the registered outputs directly so a pause silences them in the same cycle.
    assign move_left  = act_q[0] & enable;
    assign move_right = act_q[1] & enable;
    assign soft_drop  = act_q[2] & enable;
    assign rotate     = act_q[3] & enable;
    assign hard_drop  = act_q[4] & enable;
    assign key_active = enable & ((state_q == ST_DAS) || (state_q == ST_REPEAT) ||
                                  (state_q == ST_HOLD));

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Self-checking bench for tetris_key_decoder with DAS_CYCLES=4, ARR_CYCLES=2.
module tb_tetris_key_decoder;
    localparam int DAS = 4;
    localparam int ARR = 2;

    localparam logic [5:0] O_L  = 6'b000001;
    localparam logic [5:0] O_R  = 6'b000010;
    localparam logic [5:0] O_S  = 6'b000100;
    localparam logic [5:0] O_RT = 6'b001000;
    localparam logic [5:0] O_HD = 6'b010000;
    localparam logic [5:0] O_KA = 6'b100000;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [7:0] keycode;
    logic       enable;
    logic       move_left, move_right, soft_drop, rotate, hard_drop, key_active;

    always #5 clk_clk = ~clk_clk;

    tetris_key_decoder #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .keycode      (keycode),
        .enable       (enable),
        .move_left    (move_left),
        .move_right   (move_right),
        .soft_drop    (soft_drop),
        .rotate       (rotate),
        .hard_drop    (hard_drop),
        .key_active   (key_active)
    );

    wire [5:0] obs = {key_active, hard_drop, rotate, soft_drop, move_right, move_left};

    typedef struct {
        logic [7:0] kc;
        logic       en;
        logic [5:0] exp;
        string      tag;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sb_exp[$];
    string      sb_tag[$];
    int         total = 0;
    int         bad   = 0;

    function automatic void add(input logic [7:0] kc, input logic en, input logic [5:0] e,
                                input string tag);
        vec_t v;
        v.kc  = kc;
        v.en  = en;
        v.exp = e;
        v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Press from idle, hold for 'held' steps, then release for 4 steps.
    // Pulse 2 steps after the press, then (repeatable) after DAS and every ARR while held.
    function automatic void add_press(input logic [7:0] kc, input int held,
                                      input logic [5:0] act, input bit rep, input string tag);
        for (int t = 0; t < held + 4; t++) begin
            logic [5:0] e;
            e = 6'b0;
            if (t >= 2 && t <= held + 1) begin
                e = O_KA;
                if (t == 2 || (rep && t >= 2 + DAS && ((t - 2 - DAS) % ARR) == 0))
                    e = e | act;
            end
            add((t < held) ? kc : 8'h00, 1'b1, e, tag);
        end
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b (ka,hd,rot,sd,r,l)", name, got, want);
        end
    endtask

    logic [7:0] codes[10] = '{8'h50, 8'h04, 8'h4F, 8'h07, 8'h51, 8'h16, 8'h52, 8'h1A, 8'h2C, 8'h50};
    logic [5:0] acts[10]  = '{O_L, O_L, O_R, O_R, O_S, O_S, O_RT, O_RT, O_HD, O_L};
    bit         reps[10]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        reset_reset_n = 1'b0;
        keycode       = 8'h00;
        enable        = 1'b1;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check("reset_state", obs, 6'b0);
        reset_reset_n = 1'b1;

        add(8'h00, 1'b1, 6'b0, "idle");
        add(8'h00, 1'b1, 6'b0, "idle");
        add_press(8'h50, 12, O_L, 1'b1, "hold_left");
        add_press(8'h2C, 20, O_HD, 1'b0, "hard_drop_1");
        add_press(8'h2C, 4, O_HD, 1'b0, "hard_drop_2");

        // Right held, switched to left mid-DAS
        add(8'h4F, 1'b1, 6'b0, "switch");
        add(8'h4F, 1'b1, 6'b0, "switch");
        add(8'h4F, 1'b1, O_KA | O_R, "switch");
        for (int t = 3; t <= 12; t++)
            add(8'h50, 1'b1, (t == 5 || t == 9 || t == 11) ? (O_KA | O_L) : O_KA, "switch");
        add(8'h00, 1'b1, O_KA | O_L, "switch");
        add(8'h00, 1'b1, O_KA, "switch");
        add(8'h00, 1'b1, 6'b0, "switch");
        add(8'h00, 1'b1, 6'b0, "switch");

        // Soft drop held across an enable drop
        add(8'h51, 1'b1, 6'b0, "enable");
        add(8'h51, 1'b1, 6'b0, "enable");
        add(8'h51, 1'b1, O_KA | O_S, "enable");
        add(8'h51, 1'b1, O_KA, "enable");
        for (int t = 0; t < 3; t++) add(8'h51, 1'b0, 6'b0, "enable_low");
        for (int t = 0; t < 6; t++) add(8'h51, 1'b1, 6'b0, "enable_lock");
        for (int t = 0; t < 3; t++) add(8'h00, 1'b1, 6'b0, "enable_release");
        add(8'h51, 1'b1, 6'b0, "enable_repress");
        add(8'h51, 1'b1, 6'b0, "enable_repress");
        add(8'h00, 1'b1, O_KA | O_S, "enable_repress");
        add(8'h00, 1'b1, O_KA, "enable_repress");
        add(8'h00, 1'b1, 6'b0, "enable_repress");
        add(8'h00, 1'b1, 6'b0, "enable_repress");

        for (int t = 0; t < 10; t++) add(8'h00, 1'b1, 6'b0, "unmapped_00");
        for (int t = 0; t < 10; t++) add(8'h05, 1'b1, 6'b0, "unmapped_05");
        for (int t = 0; t < 10; t++) add(8'hFF, 1'b1, 6'b0, "unmapped_FF");
        for (int t = 0; t < 3; t++)  add(8'h00, 1'b1, 6'b0, "unmapped_00");

        for (int i = 0; i < 10; i++) add_press(codes[i], 2, acts[i], reps[i], "map");

        foreach (vecs[i]) begin
            @(posedge clk_clk);
            #1;
            keycode = vecs[i].kc;
            enable  = vecs[i].en;
            sb_exp.push_back(vecs[i].exp);
            sb_tag.push_back($sformatf("%s[%0d]", vecs[i].tag, i));
            @(negedge clk_clk);
            check(sb_tag.pop_front(), obs, sb_exp.pop_front());
        end

        // Asynchronous reset mid-REPEAT with D held
        for (int t = 0; t < 7; t++) begin
            @(posedge clk_clk);
            #1;
            keycode = 8'h07;
            enable  = 1'b1;
        end
        check("rst_pre_pulse", obs, O_KA | O_R);
        #2 reset_reset_n = 1'b0;
        #1 check("rst_async_clear", obs, 6'b0);
        @(negedge clk_clk);
        check("rst_held", obs, 6'b0);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("rst_first_edge", obs, 6'b0);
        @(negedge clk_clk);
        check("rst_repress", obs, O_KA | O_R);
        @(negedge clk_clk);
        check("rst_after", obs, O_KA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
